// File: rtl/uart_word_tx_if.sv
// Word-level handshake between the co-processor core and the UART transmitter.
// The core drives start/data (master); the transmitter drives line and status (slave).
interface uart_word_tx_if #(
  parameter int unsigned DATA_WIDTH = 24
);
  logic                  i_tx_start;
  logic [DATA_WIDTH-1:0] i_tx_data;
  logic                  o_tx_serial;
  logic                  o_tx_ready;
  logic                  o_tx_active;
  logic                  o_tx_done;

  modport master (
    output i_tx_start,
    output i_tx_data,
    input  o_tx_serial,
    input  o_tx_ready,
    input  o_tx_active,
    input  o_tx_done
  );

  modport slave (
    input  i_tx_start,
    input  i_tx_data,
    output o_tx_serial,
    output o_tx_ready,
    output o_tx_active,
    output o_tx_done
  );
endinterface

// File: rtl/uart_word_tx.sv
// UART word transmitter: start bit, DATA_WIDTH data bits LSB first, stop bit, no parity.
// All outputs come straight from flops, so the serial line has no combinational input path.
module uart_word_tx #(
  parameter int unsigned DATA_WIDTH   = 24,
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic           i_clk,
  input  logic           i_rst,
  uart_word_tx_if.slave  tx_if
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IdxW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);
  localparam logic [IdxW-1:0] IdxMax = IdxW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e                state_q;
  logic [CntW-1:0]       cnt_q;
  logic [IdxW-1:0]       idx_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  serial_q;
  logic                  ready_q;
  logic                  active_q;
  logic                  done_q;
  logic                  bit_end;

  assign bit_end = (cnt_q == CntMax);

  // Frame sequencer; every output is registered alongside the state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      serial_q <= 1'b1;
      ready_q  <= 1'b1;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (tx_if.i_tx_start) begin
            shift_q  <= tx_if.i_tx_data;
            cnt_q    <= '0;
            idx_q    <= '0;
            state_q  <= StStart;
            serial_q <= 1'b0;
            ready_q  <= 1'b0;
            active_q <= 1'b1;
          end
        end
        StStart: begin
          if (bit_end) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            state_q  <= StData;
            // Shift register always presents the next data bit in bit 0.
            serial_q <= shift_q[0];
            shift_q  <= shift_q >> 1;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StData: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (idx_q == IdxMax) begin
              state_q  <= StStop;
              serial_q <= 1'b1;
            end else begin
              idx_q    <= idx_q + IdxW'(1);
              serial_q <= shift_q[0];
              shift_q  <= shift_q >> 1;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StStop: begin
          if (bit_end) begin
            cnt_q    <= '0;
            state_q  <= StIdle;
            serial_q <= 1'b1;
            ready_q  <= 1'b1;
            active_q <= 1'b0;
            done_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: begin
          state_q  <= StIdle;
          serial_q <= 1'b1;
          ready_q  <= 1'b1;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign tx_if.o_tx_serial = serial_q;
  assign tx_if.o_tx_ready  = ready_q;
  assign tx_if.o_tx_active = active_q;
  assign tx_if.o_tx_done   = done_q;

endmodule

// File: tb/tb_uart_word_tx.sv
// Bench for uart_word_tx: directed scenarios plus random traffic, checked every cycle
// against a timeline model (cycles elapsed since accept -> expected line level).
module tb_uart_word_tx;

  localparam int W = 24;
  localparam int C = 4;
  localparam int L = (W + 2) * C;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_word_tx_if #(.DATA_WIDTH(W)) bus ();

  uart_word_tx #(
    .DATA_WIDTH  (W),
    .CLKS_PER_BIT(C)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .tx_if(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int done_cyc[$];

  // Reference model state
  bit         m_busy = 1'b0;
  bit         m_done = 1'b0;
  int         m_t    = 0;
  logic [W-1:0] m_word = '0;
  logic [W-1:0] rx_word = '0;
  int         act_cnt = 0;

  function automatic logic frame_bit(int t, logic [W-1:0] w);
    int k;
    k = t / C;
    if (k == 0) return 1'b0;
    else if (k <= W) return w[k-1];
    else return 1'b1;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: advance the model with the inputs present at the edge, then compare.
  task automatic step();
    logic         st;
    logic [W-1:0] dt;
    logic         rs;
    logic         exp_serial;
    st = bus.i_tx_start;
    dt = bus.i_tx_data;
    rs = rst;
    @(posedge clk);
    cyc++;
    if (rs) begin
      m_busy = 1'b0;
      m_done = 1'b0;
    end else if (m_busy) begin
      m_t++;
      if (m_t == L) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end else begin
      m_done = 1'b0;
      if (st) begin
        m_busy  = 1'b1;
        m_t     = 0;
        m_word  = dt;
        act_cnt = 0;
      end
    end
    #1;
    exp_serial = m_busy ? frame_bit(m_t, m_word) : 1'b1;
    chk("serial", 32'(bus.o_tx_serial), 32'(exp_serial));
    chk("active", 32'(bus.o_tx_active), 32'(m_busy));
    chk("ready",  32'(bus.o_tx_ready),  32'(!m_busy));
    chk("done",   32'(bus.o_tx_done),   32'(m_done));
    if (bus.o_tx_active === 1'b1) act_cnt++;
    // Receiver: sample each data bit at its centre.
    if (m_busy && (m_t % C) == C / 2 && (m_t / C) >= 1 && (m_t / C) <= W)
      rx_word[(m_t / C) - 1] = bus.o_tx_serial;
    if (m_done) begin
      chk("rx_word", 32'(rx_word), 32'(m_word));
      chk("active_len", 32'(act_cnt), 32'(L));
    end
    if (bus.o_tx_done === 1'b1) done_cyc.push_back(cyc);
  endtask

  task automatic wait_done(int max_cycles);
    bit got;
    got = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      step();
      if (bus.o_tx_done === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    chk("done_seen", 32'(got), 32'd1);
  endtask

  task automatic send(logic [W-1:0] w);
    bus.i_tx_start = 1'b1;
    bus.i_tx_data  = w;
    step();
    bus.i_tx_start = 1'b0;
  endtask

  initial begin
    int n0;
    int d;
    bus.i_tx_start = 1'b0;
    bus.i_tx_data  = '0;

    // Reset and idle
    rst = 1'b1;
    repeat (5) step();
    rst = 1'b0;
    repeat (20) step();
    chk("idle_no_done", 32'(done_cyc.size()), 32'd0);

    // Single frame with busy starts at cycles 10 and 60
    n0 = done_cyc.size();
    send(24'hA5C3F0);
    for (int i = 1; i < 120; i++) begin
      bus.i_tx_start = (i == 10 || i == 60);
      bus.i_tx_data  = (i == 10 || i == 60) ? 24'h000001 : 24'h0;
      step();
    end
    bus.i_tx_start = 1'b0;
    chk("single_one_done", 32'(done_cyc.size() - n0), 32'd1);
    chk("single_word", 32'(rx_word), 32'hA5C3F0);

    // Back-to-back frames, second start issued in the done cycle
    send(24'hFFFFFF);
    wait_done(L + 10);
    send(24'h000000);
    chk("b2b_start_bit", 32'(bus.o_tx_serial), 32'd0);
    wait_done(L + 10);
    chk("b2b_word", 32'(rx_word), 32'h000000);
    d = done_cyc[done_cyc.size()-1] - done_cyc[done_cyc.size()-2];
    chk("b2b_spacing", 32'(d), 32'(L + 1));
    repeat (3) step();

    // Reset at cycle 40 of a frame
    n0 = done_cyc.size();
    send(24'h123456);
    repeat (39) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_serial", 32'(bus.o_tx_serial), 32'd1);
    chk("abort_active", 32'(bus.o_tx_active), 32'd0);
    chk("abort_ready",  32'(bus.o_tx_ready),  32'd1);
    repeat (80) step();
    chk("abort_no_done", 32'(done_cyc.size() - n0), 32'd0);
    send(24'h654321);
    wait_done(L + 10);
    chk("after_abort_word", 32'(rx_word), 32'h654321);

    // Data changes every cycle after accept
    send(W'($urandom));
    for (int i = 0; i < L + 5; i++) begin
      bus.i_tx_data = W'($urandom);
      step();
    end

    // Random traffic: sporadic starts, random data, occasional reset
    for (int i = 0; i < 600; i++) begin
      bus.i_tx_start = ($urandom_range(0, 15) == 0);
      bus.i_tx_data  = W'($urandom);
      rst            = ($urandom_range(0, 299) == 0);
      step();
    end
    rst            = 1'b0;
    bus.i_tx_start = 1'b0;
    repeat (L + 5) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
